// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: debounces presses, waits for a release, builds a BCD entry and commits it.
// Optional: define KEYPAD_AUTO_COMMIT_EN to commit automatically when the buffer fills.
module keypad_entry_ctrl #(
  parameter int DIGITS  = 4,
  parameter int DEB_CYC = 4,
  parameter int REL_CYC = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  V_IN,
  input  logic [3:0]            N_IN,
  output logic                  KEY_STB,
  output logic [3:0]            KEY_CODE,
  output logic [4*DIGITS-1:0]   ENTRY,
  output logic [3:0]            COUNT,
  output logic                  OVF,
  output logic [4*DIGITS-1:0]   RESULT,
  output logic [3:0]            RESULT_CNT,
  output logic                  DONE
);

  localparam int         EW       = 4 * DIGITS;
  localparam logic [3:0] DIGITS_W = 4'(DIGITS);
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);
  localparam logic [7:0] REL_W    = 8'(REL_CYC);

`ifdef KEYPAD_AUTO_COMMIT_EN
  localparam bit AUTO_COMMIT = 1'b1;
`else
  localparam bit AUTO_COMMIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESS, WAIT_REL} state_e;

  state_e          state_q, state_d;
  logic [3:0]      pend_q, pend_d;
  logic [7:0]      deb_q, deb_d;
  logic [7:0]      rel_q, rel_d;
  logic            key_stb_q, key_stb_d;
  logic [3:0]      key_code_q, key_code_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [3:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [EW-1:0]   result_q, result_d;
  logic [3:0]      result_cnt_q, result_cnt_d;
  logic            done_q, done_d;
  logic [EW-1:0]   entry_shift;

  assign entry_shift = (entry_q << 4) | EW'(pend_q);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    pend_d       = pend_q;
    deb_d        = deb_q;
    rel_d        = rel_q;
    key_stb_d    = 1'b0;
    key_code_d   = key_code_q;
    entry_d      = entry_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    result_d     = result_q;
    result_cnt_d = result_cnt_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (V_IN) begin
          pend_d  = N_IN;
          deb_d   = 8'd1;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!V_IN || N_IN != pend_q) begin
          state_d = IDLE;
        end else begin
          deb_d = deb_q + 8'd1;
          if (deb_q == DEB_LAST) state_d = PRESS;
        end
      end
      PRESS: begin
        state_d = WAIT_REL;
        rel_d   = 8'd0;
        // Codes 12-15 take no action and leave KEY_CODE alone.
        if (pend_q <= 4'd11) begin
          key_stb_d  = 1'b1;
          key_code_d = pend_q;
        end
        if (pend_q < 4'd10) begin
          if (count_q < DIGITS_W) begin
            entry_d = entry_shift;
            count_d = count_q + 4'd1;
            if (AUTO_COMMIT && count_q == DIGITS_W - 4'd1) begin
              result_d     = entry_shift;
              result_cnt_d = DIGITS_W;
              done_d       = 1'b1;
              entry_d      = '0;
              count_d      = 4'd0;
            end
          end else begin
            ovf_d = ~AUTO_COMMIT;
          end
        end else if (pend_q == 4'd10) begin
          entry_d = '0;
          count_d = 4'd0;
          ovf_d   = 1'b0;
        end else if (pend_q == 4'd11 && count_q != 4'd0) begin
          result_d     = entry_q;
          result_cnt_d = count_q;
          done_d       = 1'b1;
          entry_d      = '0;
          count_d      = 4'd0;
          ovf_d        = 1'b0;
        end
      end
      WAIT_REL: begin
        // A held key only restarts the release count; it never re-triggers.
        if (V_IN) begin
          rel_d = 8'd0;
        end else begin
          rel_d = rel_q + 8'd1;
          if (rel_q + 8'd1 == REL_W) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      pend_q       <= 4'd0;
      deb_q        <= 8'd0;
      rel_q        <= 8'd0;
      key_stb_q    <= 1'b0;
      key_code_q   <= 4'd0;
      entry_q      <= '0;
      count_q      <= 4'd0;
      ovf_q        <= 1'b0;
      result_q     <= '0;
      result_cnt_q <= 4'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      deb_q        <= deb_d;
      rel_q        <= rel_d;
      key_stb_q    <= key_stb_d;
      key_code_q   <= key_code_d;
      entry_q      <= entry_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      result_q     <= result_d;
      result_cnt_q <= result_cnt_d;
      done_q       <= done_d;
    end
  end

  assign KEY_STB    = key_stb_q;
  assign KEY_CODE   = key_code_q;
  assign ENTRY      = entry_q;
  assign COUNT      = count_q;
  assign OVF        = ovf_q;
  assign RESULT     = result_q;
  assign RESULT_CNT = result_cnt_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: each accepted key pushes its expected post-press state,
// and a monitor pops and compares whenever KEY_STB fires.
module tb_keypad_entry_ctrl;

  localparam int DIGITS  = 4;
  localparam int DEB_CYC = 4;
  localparam int REL_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_in;
  logic [3:0]  n_in;
  logic        key_stb;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [3:0]  count;
  logic        ovf;
  logic [15:0] result;
  logic [3:0]  result_cnt;
  logic        done;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] entry;
    logic [3:0]  count;
    logic        ovf;
    logic        done;
    logic [15:0] result;
    logic [3:0]  rcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stb_count = 0;

  logic [15:0] m_entry;
  logic [3:0]  m_count;
  logic        m_ovf;
  logic [15:0] m_result;
  logic [3:0]  m_rcnt;

  keypad_entry_ctrl #(.DIGITS(DIGITS), .DEB_CYC(DEB_CYC), .REL_CYC(REL_CYC)) dut (
    .CLK(clk), .RESET_N(rst_n), .V_IN(v_in), .N_IN(n_in),
    .KEY_STB(key_stb), .KEY_CODE(key_code), .ENTRY(entry), .COUNT(count),
    .OVF(ovf), .RESULT(result), .RESULT_CNT(result_cnt), .DONE(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (key_stb === 1'b1) begin
      stb_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_stb: got code=%0d entry=%h, expected no strobe", key_code, entry);
      end else begin
        e = exp_q.pop_front();
        if ({key_code, entry, count, ovf, done, result, result_cnt} !==
            {e.code, e.entry, e.count, e.ovf, e.done, e.result, e.rcnt}) begin
          errors++;
          $display("FAIL key_%0d: got code=%0d entry=%h cnt=%0d ovf=%b done=%b res=%h rcnt=%0d, expected code=%0d entry=%h cnt=%0d ovf=%b done=%b res=%h rcnt=%0d",
                   e.code, key_code, entry, count, ovf, done, result, result_cnt,
                   e.code, e.entry, e.count, e.ovf, e.done, e.result, e.rcnt);
        end
      end
    end else if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_without_stb: got done=%b, expected 0", done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_entry = '0; m_count = '0; m_ovf = 1'b0; m_result = '0; m_rcnt = '0;
  endtask

  // Advances the reference model for one accepted key and queues its expected outputs.
  task automatic expect_key(input logic [3:0] code);
    exp_t e;
    e.done = 1'b0;
    if (code < 4'd10) begin
      if (m_count < 4'(DIGITS)) begin
        m_entry = {m_entry[11:0], code};
        m_count = m_count + 4'd1;
`ifdef KEYPAD_AUTO_COMMIT_EN
        if (m_count == 4'(DIGITS)) begin
          m_result = m_entry; m_rcnt = m_count; e.done = 1'b1;
          m_entry = '0; m_count = '0;
        end
`endif
      end else begin
        m_ovf = 1'b1;
      end
    end else if (code == 4'd10) begin
      m_entry = '0; m_count = '0; m_ovf = 1'b0;
    end else if (code == 4'd11 && m_count != 4'd0) begin
      m_result = m_entry; m_rcnt = m_count; e.done = 1'b1;
      m_entry = '0; m_count = '0; m_ovf = 1'b0;
    end
    if (code <= 4'd11) begin
      e.code = code; e.entry = m_entry; e.count = m_count; e.ovf = m_ovf;
      e.result = m_result; e.rcnt = m_rcnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    if (hold >= DEB_CYC) expect_key(code);
    v_in = 1'b1;
    n_in = code;
    repeat (hold) tick();
    v_in = 1'b0;
    repeat (rel) tick();
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d strobes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v_in = 1'b0; n_in = 4'd0;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({key_stb, key_code, entry, count, ovf, result, result_cnt, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got stb=%b code=%0d entry=%h cnt=%0d ovf=%b res=%h rcnt=%0d done=%b, expected all 0",
               key_stb, key_code, entry, count, ovf, result, result_cnt, done);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_clean_entry();
    int s0;
    s0 = stb_count;
    press(4'd1, 6, 6);
    press(4'd2, 6, 6);
    press(4'd3, 6, 6);
    press(4'd4, 6, 6);
    press(4'd11, 6, 6);
    checks++;
    if (stb_count - s0 != 5) begin
      errors++;
      $display("FAIL clean_stb_count: got %0d, expected 5", stb_count - s0);
    end
    checks++;
    if ({result, result_cnt, entry, count} !== {16'h1234, 4'd4, 16'h0000, 4'd0}) begin
      errors++;
      $display("FAIL clean_commit: got res=%h rcnt=%0d entry=%h cnt=%0d, expected res=1234 rcnt=4 entry=0000 cnt=0",
               result, result_cnt, entry, count);
    end
    check_drained("clean");
  endtask

  task automatic test_bounce();
    v_in = 1'b1; n_in = 4'd5;
    repeat (3) tick();
    v_in = 1'b0;
    tick();
    v_in = 1'b1;
    repeat (3) tick();
    v_in = 1'b0;
    repeat (6) tick();
    check_drained("bounce");
    // N changes from 5 to 6 on the second debounce edge, then 6 is held.
    v_in = 1'b1; n_in = 4'd5;
    tick();
    n_in = 4'd6;
    tick();
    expect_key(4'd6);
    for (int i = 1; i <= DEB_CYC + 1; i++) begin
      tick();
      checks++;
      if (key_stb !== (i == DEB_CYC + 1)) begin
        errors++;
        $display("FAIL bounce_latency_edge%0d: got stb=%b, expected %b", i, key_stb, i == DEB_CYC + 1);
      end
    end
    v_in = 1'b0;
    repeat (6) tick();
    check_drained("bounce_change");
  endtask

  task automatic test_held_key();
    int s0;
    press(4'd10, 6, 6);
    s0 = stb_count;
    expect_key(4'd7);
    n_in = 4'd7;
    for (int i = 0; i < 50; i++) begin
      v_in = (i % 10 == 9) ? 1'b0 : 1'b1;
      tick();
    end
    v_in = 1'b0;
    repeat (6) tick();
    checks++;
    if (stb_count - s0 != 1 || count !== 4'd1) begin
      errors++;
      $display("FAIL held_key: got stb=%0d cnt=%0d, expected stb=1 cnt=1", stb_count - s0, count);
    end
    check_drained("held");
  endtask

  task automatic test_overflow_clear();
    press(4'd10, 6, 6);
    press(4'd9, 6, 6);
    press(4'd8, 6, 6);
    press(4'd7, 6, 6);
    press(4'd6, 6, 6);
    press(4'd5, 6, 6);
    checks++;
    if ({entry, count, ovf} !== {16'h9876, 4'd4, 1'b1}) begin
      errors++;
      $display("FAIL overflow: got entry=%h cnt=%0d ovf=%b, expected entry=9876 cnt=4 ovf=1", entry, count, ovf);
    end
    press(4'd10, 6, 6);
    checks++;
    if ({entry, count, ovf} !== {16'h0000, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL clear: got entry=%h cnt=%0d ovf=%b, expected entry=0000 cnt=0 ovf=0", entry, count, ovf);
    end
    check_drained("overflow");
  endtask

  task automatic test_edge_keys();
    int s0;
    s0 = stb_count;
    press(4'd11, 6, 6);
    press(4'd14, 6, 6);
    checks++;
    if (stb_count - s0 != 1 || key_code !== 4'd11 || result !== 16'h1234 || result_cnt !== 4'd4) begin
      errors++;
      $display("FAIL edge_keys: got stb=%0d code=%0d res=%h rcnt=%0d, expected stb=1 code=11 res=1234 rcnt=4",
               stb_count - s0, key_code, result, result_cnt);
    end
    check_drained("edge");
  endtask

  task automatic test_reset_mid_press();
    v_in = 1'b1; n_in = 4'd3;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_stb, key_code, entry, count, ovf, result, result_cnt, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: got code=%0d res=%h rcnt=%0d entry=%h, expected all 0",
               key_code, result, result_cnt, entry);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
    expect_key(4'd3);
    for (int i = 1; i <= DEB_CYC + 1; i++) begin
      tick();
      checks++;
      if (key_stb !== (i == DEB_CYC + 1)) begin
        errors++;
        $display("FAIL post_reset_edge%0d: got stb=%b, expected %b", i, key_stb, i == DEB_CYC + 1);
      end
    end
    v_in = 1'b0;
    repeat (6) tick();
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_clean_entry();
    test_bounce();
    test_held_key();
    test_overflow_clear();
    test_edge_keys();
    test_reset_mid_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
